// File: rtl/opcode_decode_pipe.sv
// rtl/opcode_decode_pipe.sv - buffered, flow-controlled one-hot opcode decoder
//
// Purpose: accepts {opcode[3:0], RX, RY} instruction words from one of two
// sources through a valid/ready handshake, queues them in a DEPTH-entry FIFO
// and presents {RX, RY, onehot[22:0]} from an output register with its own
// valid/ready handshake.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear of FIFO and output stage
//   src_sel      in   0 = instr_single, 1 = instr_multi (sampled on accept)
//   instr_single in   IW  instruction word from the single-cycle path
//   instr_multi  in   IW  instruction word from the multicycle path
//   dec_en       in   0 zeroes the one-hot field of the accepted word
//   in_valid     in   upstream word present
//   in_ready     out  block can accept this cycle
//   out_valid    out  opcode_out holds a decoded instruction
//   out_ready    in   downstream consumes opcode_out
//   opcode_out   out  OW  {RX, RY, onehot[22:0]}
//   fifo_count   out  CW  words buffered in the FIFO (output register excluded)

module opcode_decode_pipe #(
    parameter  int REG_BITS = 2,
    parameter  int DEPTH    = 2,
    localparam int IW       = 4 + 2 * REG_BITS,
    localparam int OW       = 23 + 2 * REG_BITS,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          src_sel,
    input  logic [IW-1:0] instr_single,
    input  logic [IW-1:0] instr_multi,
    input  logic          dec_en,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] opcode_out,
    output logic [CW-1:0] fifo_count
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Words are decoded before entering the FIFO, so the FIFO and the output
    // register both hold the final output format.
    function automatic logic [OW-1:0] decode(input logic [IW-1:0] w, input logic en);
        logic [3:0]  op;
        logic [1:0]  ry2;
        logic [4:0]  idx;
        logic [22:0] oh;
        op  = w[IW-1 -: 4];
        ry2 = w[1:0];
        case (op)
            4'd0:    idx = 5'd0;
            4'd1:    idx = 5'd1 + {3'b000, ry2};
            4'd12:   idx = 5'd15 + {4'b0000, ry2[0]};
            4'd13:   idx = 5'd17;
            4'd14:   idx = 5'd18;
            4'd15:   idx = 5'd19 + {3'b000, ry2};
            default: idx = {1'b0, op} + 5'd3;
        endcase
        oh = en ? (23'd1 << idx) : 23'd0;
        return {w[2*REG_BITS-1:0], oh};
    endfunction

    logic [OW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;

    logic [IW-1:0] in_word;
    logic [OW-1:0] in_dec;
    logic          fifo_empty;
    logic          accept;
    logic          load;
    logic          pop;
    logic          bypass;
    logic          push;

    assign in_word    = src_sel ? instr_multi : instr_single;
    assign in_dec     = decode(in_word, dec_en);
    assign fifo_empty = (count_q == '0);

    // in_ready looks only at the FIFO occupancy; a pop in the same cycle
    // frees a slot for the next cycle, never this one.
    assign in_ready   = (count_q < DEPTH_C) && !flush;
    assign accept     = in_valid && in_ready;
    assign load       = !out_valid_q || out_ready;
    assign pop        = load && !fifo_empty;
    // Bypass straight to the output register only when nothing is queued,
    // which keeps words in arrival order.
    assign bypass     = accept && load && fifo_empty;
    assign push       = accept && !bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (load) begin
                if (!fifo_empty) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[rd_ptr_q];
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_dec;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_dec;
        end
    end

    assign out_valid  = out_valid_q;
    assign opcode_out = out_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_opcode_decode_pipe.sv
// tb/tb_opcode_decode_pipe.sv - self-checking bench for opcode_decode_pipe

module tb_opcode_decode_pipe;

    localparam int RB    = 2;
    localparam int DEPTH = 4;
    localparam int IW    = 4 + 2 * RB;
    localparam int OW    = 23 + 2 * RB;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic          src_sel;
    logic [IW-1:0] instr_single;
    logic [IW-1:0] instr_multi;
    logic          dec_en;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] opcode_out;
    logic [CW-1:0] fifo_count;

    opcode_decode_pipe #(.REG_BITS(RB), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .src_sel      (src_sel),
        .instr_single (instr_single),
        .instr_multi  (instr_multi),
        .dec_en       (dec_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode_out   (opcode_out),
        .fifo_count   (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // Every word accepted and not yet consumed, oldest first; the head is
    // what the output register should hold.
    logic [OW-1:0] model_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] ref_word(input logic [IW-1:0] w, input bit en);
        int k, rx, ry, b;
        logic [OW-1:0] r;
        k  = int'(w) / (1 << (2 * RB));
        rx = (int'(w) / (1 << RB)) % (1 << RB);
        ry = int'(w) % (1 << RB);
        r  = (OW'(rx) << (23 + RB)) | (OW'(ry) << 23);
        if (en) begin
            if (k == 0)       b = 0;
            else if (k == 1)  b = 1 + ry % 4;
            else if (k <= 11) b = k + 3;
            else if (k == 12) b = 15 + ry % 2;
            else if (k == 13) b = 17;
            else if (k == 14) b = 18;
            else              b = 19 + ry % 4;
            r = r | (OW'(1) << b);
        end
        return r;
    endfunction

    function automatic int exp_count();
        return (model_q.size() > 0) ? model_q.size() - 1 : 0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
        check({tag, ".fifo_count"}, 64'(fifo_count), 64'(exp_count()));
        if (model_q.size() > 0) begin
            check({tag, ".opcode_out"}, 64'(opcode_out), 64'(model_q[0]));
        end
    endtask

    // Called just after a falling edge: drive, check in_ready, advance the
    // model, cross the rising edge and check outputs at the next falling edge.
    task automatic step(input string tag, input bit iv, input bit ss, input bit de,
                        input logic [IW-1:0] ws, input logic [IW-1:0] wm,
                        input bit ordy, input bit fl);
        bit exp_rdy;
        bit ov;
        in_valid     = iv;
        src_sel      = ss;
        dec_en       = de;
        instr_single = ws;
        instr_multi  = wm;
        out_ready    = ordy;
        flush        = fl;
        #1;
        exp_rdy = (exp_count() < DEPTH) && !fl;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        ov = model_q.size() > 0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (ov && ordy) void'(model_q.pop_front());
            if (iv && exp_rdy) model_q.push_back(ref_word(ss ? wm : ws, de));
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs(tag);
    endtask

    initial begin
        logic [IW-1:0] w;
        reset_n      = 1'b0;
        flush        = 1'b0;
        src_sel      = 1'b0;
        instr_single = '0;
        instr_multi  = '0;
        dec_en       = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.opcode_out", 64'(opcode_out), 64'(0));
        check("rst.fifo_count", 64'(fifo_count), 64'(0));
        reset_n = 1'b1;

        // Single word with bypass: 8'h1E -> onehot bit 3.
        step("tp1", 1, 0, 1, 8'h1E, 8'h00, 1, 0);
        check("tp1.value", 64'(opcode_out), 64'({2'b11, 2'b10, 23'h000008}));
        step("tp1.idle", 0, 0, 1, 8'h00, 8'h00, 1, 0);

        // Full-rate stream of all opcodes from the multicycle source.
        for (int k = 0; k < 16; k++) begin
            w = {4'(k), 2'($urandom), 2'b11};
            step("stream", 1, 1, 1, IW'($urandom), w, 1, 0);
        end
        step("stream.tail", 0, 0, 1, 8'h00, 8'h00, 1, 0);

        // Stall the output and overfill, then drain with input still offered.
        for (int i = 0; i < DEPTH + 2; i++) begin
            step("fill", 1, 0, 1, IW'($urandom), IW'($urandom), 0, 0);
        end
        check("fill.count", 64'(fifo_count), 64'(DEPTH));
        check("fill.in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < DEPTH + 4; i++) begin
            step("drain", i < 2, 1, 1, IW'($urandom), IW'($urandom), 1, 0);
        end

        // dec_en = 0 passes fields through with no one-hot bit.
        step("nodec", 1, 0, 0, 8'hF5, 8'h00, 1, 0);
        check("nodec.value", 64'(opcode_out), 64'({2'b01, 2'b01, 23'h0}));
        step("nodec.idle", 0, 0, 1, 8'h00, 8'h00, 1, 0);

        // Flush with two words buffered and a word offered the same cycle.
        for (int i = 0; i < 3; i++) begin
            step("preflush", 1, 0, 1, IW'($urandom), IW'($urandom), 0, 0);
        end
        step("flush", 1, 0, 1, 8'h77, 8'h00, 1, 1);
        step("postflush", 0, 0, 1, 8'h00, 8'h00, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 7) != 0, IW'($urandom), IW'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset between edges with words in flight.
        for (int i = 0; i < 3; i++) begin
            step("prereset", 1, 0, 1, IW'($urandom), IW'($urandom), 0, 0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        check("areset.out_valid", 64'(out_valid), 64'(0));
        check("areset.opcode_out", 64'(opcode_out), 64'(0));
        check("areset.fifo_count", 64'(fifo_count), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        step("after_reset", 1, 0, 1, 8'hC1, 8'h00, 1, 0);
        check("after_reset.onehot", 64'(opcode_out[22:0]), 64'(23'd1 << 16));
        step("after_reset.idle", 0, 0, 1, 8'h00, 8'h00, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
